// File: rtl/rs_encoder.sv
// Symbol-serial systematic RS(K+2,K) encoder over GF(8), g(x) = x^2 + a^4*x + a^3.
// Optional parallel codeword output is enabled by defining RS_ENC_PARALLEL_OUT_EN.
module rs_encoder #(
    parameter int SYMBOL_WIDTH = 3,
    parameter int K            = 5,
    parameter int N            = K + 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SYMBOL_WIDTH-1:0]   in_symbol,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SYMBOL_WIDTH-1:0]   out_symbol,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [1:0]                o_dbg_state
`ifdef RS_ENC_PARALLEL_OUT_EN
    ,
    output logic                      cw_valid,
    output logic [N*SYMBOL_WIDTH-1:0] cw_data
`endif
);

    localparam int SW    = SYMBOL_WIDTH;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_MSG  = 2'd0,
        S_PAR1 = 2'd1,
        S_PAR2 = 2'd2
    } state_t;

    // Multiply by a: bit[2] holds the a^0 coefficient, bit[0] the a^2 coefficient.
    function automatic logic [SW-1:0] mul_a(input logic [SW-1:0] x);
        return {x[0], x[2] ^ x[0], x[1]};
    endfunction

    function automatic logic [SW-1:0] mul_a3(input logic [SW-1:0] x);
        return mul_a(mul_a(mul_a(x)));
    endfunction

    function automatic logic [SW-1:0] mul_a4(input logic [SW-1:0] x);
        return mul_a(mul_a3(x));
    endfunction

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SW-1:0]     r_r0;
    logic [SW-1:0]     r_r1;
    logic              r_out_valid;
    logic [SW-1:0]     r_out_symbol;
    logic              r_out_sop;
    logic              r_out_eop;

    logic              w_free;
    logic              w_accept;
    logic              w_load;
    logic [SW-1:0]     w_load_sym;
    logic [SW-1:0]     w_fb;

    assign w_free   = !r_out_valid || out_ready;
    assign in_ready = (r_state == S_MSG) && w_free && !reset;
    assign w_accept = in_valid && in_ready;
    assign w_fb     = in_symbol ^ r_r1;

    always_comb begin
        w_load     = 1'b0;
        w_load_sym = '0;
        case (r_state)
            S_MSG: begin
                w_load     = w_accept;
                w_load_sym = in_symbol;
            end
            S_PAR1: begin
                w_load     = w_free;
                w_load_sym = r_r1;
            end
            S_PAR2: begin
                w_load     = w_free;
                w_load_sym = r_r0;
            end
            default: begin
                w_load     = 1'b0;
                w_load_sym = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_MSG;
            r_cnt        <= '0;
            r_r0         <= '0;
            r_r1         <= '0;
            r_out_valid  <= 1'b0;
            r_out_symbol <= '0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_symbol <= w_load_sym;
            end
            case (r_state)
                S_MSG: begin
                    if (w_accept) begin
                        r_out_sop <= (r_cnt == '0);
                        r_out_eop <= 1'b0;
                        r_r1      <= r_r0 ^ mul_a4(w_fb);
                        r_r0      <= mul_a3(w_fb);
                        if (r_cnt == CNT_W'(K - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_PAR1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_PAR1: begin
                    if (w_free) begin
                        r_out_sop <= 1'b0;
                        r_out_eop <= 1'b0;
                        r_state   <= S_PAR2;
                    end
                end
                S_PAR2: begin
                    // Clearing the remainder here lets the next frame start without a bubble.
                    if (w_free) begin
                        r_out_sop <= 1'b0;
                        r_out_eop <= 1'b1;
                        r_r0      <= '0;
                        r_r1      <= '0;
                        r_state   <= S_MSG;
                    end
                end
                default: begin
                    r_state <= S_MSG;
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_symbol  = r_out_symbol;
    assign out_sop     = r_out_sop;
    assign out_eop     = r_out_eop;
    assign o_dbg_state = r_state;

`ifdef RS_ENC_PARALLEL_OUT_EN
    logic [N*SW-1:0] r_cw_sh;
    logic [N*SW-1:0] r_cw_data;
    logic            r_cw_valid;

    // The shift register tracks every loaded symbol; the snapshot is taken on the last parity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cw_sh    <= '0;
            r_cw_data  <= '0;
            r_cw_valid <= 1'b0;
        end else begin
            r_cw_valid <= 1'b0;
            if (w_load) begin
                r_cw_sh <= {r_cw_sh[N*SW-SW-1:0], w_load_sym};
            end
            if (w_load && (r_state == S_PAR2)) begin
                r_cw_data  <= {r_cw_sh[N*SW-SW-1:0], w_load_sym};
                r_cw_valid <= 1'b1;
            end
        end
    end

    assign cw_valid = r_cw_valid;
    assign cw_data  = r_cw_data;
`endif

endmodule

// File: tb/tb_rs_encoder.sv
// Randomized scoreboard bench for rs_encoder (K=5): model by polynomial long division,
// plus syndrome checks c(a)=c(a^2)=0 on every observed codeword.
module tb_rs_encoder;

    localparam int K = 5;
    localparam int N = K + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_symbol;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_symbol;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  dbg_state;
`ifdef RS_ENC_PARALLEL_OUT_EN
    logic        cw_valid;
    logic [20:0] cw_data;
    logic [20:0] cw_q[$];
    logic        cw_prev = 1'b0;
`endif

    logic [4:0]  exp_q[$];
    logic [2:0]  cw_buf[$];
    logic [2:0]  gexp[7];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          rand_ready = 1'b0;
    int          run = 0;
    int          max_run = 0;
    int          sop_cyc = 0;
    int          eop_cyc = 0;
    int          acc = 0;
    int          par_left = 0;
    logic        stall_prev = 1'b0;
    logic [5:0]  held = '0;
    logic [2:0]  last_p1 = '0;
    logic [2:0]  last_p2 = '0;

    rs_encoder #(.SYMBOL_WIDTH(3), .K(K)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_symbol  (in_symbol),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_symbol (out_symbol),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .o_dbg_state(dbg_state)
`ifdef RS_ENC_PARALLEL_OUT_EN
        ,
        .cw_valid   (cw_valid),
        .cw_data    (cw_data)
`endif
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // GF(8) reference arithmetic from the power table
    function automatic logic [2:0] gf_mul(input logic [2:0] x, input logic [2:0] y);
        int lx;
        int ly;
        lx = 0;
        ly = 0;
        if (x == 3'b000 || y == 3'b000) return 3'b000;
        for (int i = 0; i < 7; i++) begin
            if (gexp[i] == x) lx = i;
            if (gexp[i] == y) ly = i;
        end
        return gexp[(lx + ly) % 7];
    endfunction

    function automatic logic [2:0] eval_cw(input logic [2:0] pt);
        logic [2:0] a;
        a = 3'b000;
        foreach (cw_buf[i]) a = gf_mul(a, pt) ^ cw_buf[i];
        return a;
    endfunction

    // Driver tasks
    task automatic send_sym(input logic [2:0] s);
        int  t;
        bit  done;
        t = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_symbol = s;
        while (!done && t < 500) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                t++;
            end
        end
        in_valid = 1'b0;
        in_symbol = 3'($urandom);
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: symbol %0h not accepted in 500 cycles", s);
        end
    endtask

    task automatic send_frame(input logic [14:0] msg, input int gap_max);
        logic [2:0] rem[7];
        logic [2:0] c;
        for (int i = 0; i < 5; i++) rem[i] = msg[14 - 3*i -: 3];
        rem[5] = 3'b000;
        rem[6] = 3'b000;
        // Remainder of m(x)*x^2 divided by g(x) = x^2 + a^4 x + a^3
        for (int i = 0; i < 5; i++) begin
            c = rem[i];
            rem[i+1] = rem[i+1] ^ gf_mul(c, 3'b011);
            rem[i+2] = rem[i+2] ^ gf_mul(c, 3'b110);
        end
        for (int i = 0; i < 5; i++) exp_q.push_back({(i == 0), 1'b0, msg[14 - 3*i -: 3]});
        exp_q.push_back({2'b00, rem[5]});
        exp_q.push_back({2'b01, rem[6]});
`ifdef RS_ENC_PARALLEL_OUT_EN
        cw_q.push_back({msg, rem[5], rem[6]});
`endif
        for (int i = 0; i < 5; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_sym(msg[14 - 3*i -: 3]);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: %0d expected symbols never appeared", exp_q.size());
            exp_q.delete();
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [4:0] e;
        if (reset) begin
            stall_prev = 1'b0;
            acc = 0;
            par_left = 0;
            run = 0;
            cw_buf.delete();
        end else begin
            if (stall_prev) check("stall_hold", {out_valid, out_sop, out_eop, out_symbol}, held);
            stall_prev = out_valid && !out_ready;
            held = {out_valid, out_sop, out_eop, out_symbol};

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_symbol, 8);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {out_sop, out_eop, out_symbol}, e);
                end
                if (out_sop) begin
                    cw_buf.delete();
                    sop_cyc = cyc;
                end
                cw_buf.push_back(out_symbol);
                if (out_eop) begin
                    eop_cyc = cyc;
                    check("cw_len", cw_buf.size(), N);
                    check("syndrome_a", eval_cw(3'b010), 0);
                    check("syndrome_a2", eval_cw(3'b001), 0);
                    if (cw_buf.size() == N) begin
                        last_p1 = cw_buf[5];
                        last_p2 = cw_buf[6];
                    end
                end
            end

            run = out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;

            if (par_left > 0) begin
                check("in_ready_in_parity", in_ready, 0);
                if (!out_valid || out_ready) par_left--;
            end else if (in_valid && in_ready) begin
                acc++;
                if (acc == K) begin
                    acc = 0;
                    par_left = 2;
                end
            end
        end
`ifdef RS_ENC_PARALLEL_OUT_EN
        if (cw_valid) begin
            check("cw_valid_one_cycle", cw_prev, 0);
            if (cw_q.size() == 0) check("cw_unexpected", cw_data, 0);
            else check("cw_data", cw_data, cw_q.pop_front());
        end
        cw_prev = cw_valid;
`endif
    end

    // Main sequence
    initial begin
        gexp = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b111, 3'b101};
        reset = 1'b1;
        in_valid = 1'b0;
        in_symbol = 3'b000;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_out_valid", out_valid, 0);
        check("rst_out_symbol", out_symbol, 0);
        check("rst_out_sop", out_sop, 0);
        check("rst_out_eop", out_eop, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        send_frame(15'b000_000_000_000_000, 0);
        wait_drain();
        check("zero_p1", last_p1, 3'b000);
        check("zero_p2", last_p2, 3'b000);
        check("zero_frame_span", eop_cyc - sop_cyc, 6);

        send_frame(15'b000_000_000_000_100, 0);
        wait_drain();
        check("last1_p1", last_p1, 3'b011);
        check("last1_p2", last_p2, 3'b110);

        send_frame(15'b100_000_000_000_000, 0);
        wait_drain();
        check("first1_p1", last_p1, 3'b011);
        check("first1_p2", last_p2, 3'b010);

        max_run = 0;
        send_frame(15'b000_000_000_000_100, 0);
        send_frame(15'b100_000_000_000_000, 0);
        wait_drain();
        check("b2b_valid_run", max_run, 14);
        check("b2b_p1", last_p1, 3'b011);
        check("b2b_p2", last_p2, 3'b010);

        rand_ready = 1'b1;
        for (int f = 0; f < 12; f++) send_frame(15'($urandom), 3);
        wait_drain();
        rand_ready = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(15'($urandom), 0);
        wait_drain();

        exp_q.push_back({2'b10, 3'b011});
        exp_q.push_back({2'b00, 3'b111});
        send_sym(3'b011);
        send_sym(3'b111);
        send_sym(3'b101);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_symbol", out_symbol, 3'b101);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_symbol", out_symbol, 0);
        check("async_rst_sop", out_sop, 0);
        check("async_rst_in_ready", in_ready, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_frame(15'b000_000_000_000_100, 0);
        wait_drain();
        check("post_rst_p1", last_p1, 3'b011);
        check("post_rst_p2", last_p2, 3'b110);
`ifdef RS_ENC_PARALLEL_OUT_EN
        check("cw_all_seen", cw_q.size(), 0);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rs_encoder.md
Name: rs_encoder

Overview:
- Symbol-serial systematic Reed-Solomon encoder over GF(8): RS(7,5), or shortened RS(K+2,K).
- Transmit-side counterpart of RS_Decoder; produces the codewords the decoder corrects.
- Accepts K message symbols on a valid/ready stream, passes them through, then appends 2 parity symbols.
- Generator g(x) = x^2 + a^4*x + a^3, where a is a root of x^3+x+1.
- Symbol bit order: bit[2]=a^0, bit[1]=a^1, bit[0]=a^2.
- Power table: a^0=100, a^1=010, a^2=001, a^3=110, a^4=011, a^5=111, a^6=101.

Parameters:
- SYMBOL_WIDTH, 3: bits per symbol; only 3 is legal.
- K, 5: message symbols per frame; legal range 1..5 (K<5 is a shortened code).
- N, K+2: codeword symbols per frame; derived, must not be overridden.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  message symbol valid
- in_ready  out  1  encoder accepts a symbol this cycle
- in_symbol  in  SYMBOL_WIDTH  message symbol, highest-degree coefficient first
- out_valid  out  1  output symbol valid
- out_ready  in  1  downstream accepts a symbol this cycle
- out_symbol  out  SYMBOL_WIDTH  codeword symbol
- out_sop  out  1  marks the first symbol of a codeword
- out_eop  out  1  marks the last (second parity) symbol of a codeword

Behaviour:
- Reset (async assert) forces: state=MSG, cnt=0, r0=r1=0, out_valid=0, out_symbol=0, out_sop=0, out_eop=0.
- in_ready is combinational and low during reset.
- Output register: single stage. free = !out_valid || out_ready. On a load, out_valid=1; otherwise out_valid is cleared when out_ready=1.
- State machine states: MSG, PAR1, PAR2.
- MSG state:
  - in_ready = free.
  - Accept = in_valid && in_ready.
  - On accept: out_symbol <= in_symbol; out_sop <= (cnt==0); out_eop <= 0.
  - LFSR update on accept: f = in_symbol ^ r1; r1 <= r0 ^ (a^4 * f); r0 <= a^3 * f.
  - On accept, cnt increments. Accept with cnt==K-1 sets cnt <= 0 and moves to PAR1.
- PAR1 state: in_ready=0. When free: out_symbol <= r1, sop=0, eop=0; go to PAR2.
- PAR2 state: in_ready=0. When free: out_symbol <= r0, eop=1; clear r0 and r1; go to MSG.
- Latency: a symbol accepted on edge t is presented with out_valid=1 after edge t.
- Throughput: K+2 cycles per frame with no backpressure. Back-to-back frames have no bubble; in_ready rises in the cycle after the PAR2 load.
- Backpressure: out_valid=1 && out_ready=0 holds out_symbol, out_sop, out_eop and all state stable. in_ready is 0 during stall.
- in_valid=0 mid-frame: state, cnt and LFSR hold; no timeout.
- GF multiply by constants a^3 and a^4 is pure XOR logic. No log/antilog tables.
- Async reset mid-frame discards the partial frame. The next accepted symbol starts a new frame with out_sop=1.
- in_symbol is ignored when not accepted (X-tolerant).

Optional Feature:
- Macro: RS_ENC_PARALLEL_OUT_EN
- When defined, two extra outputs are added:
  - cw_valid (1 bit): one-cycle pulse.
  - cw_data (N*SYMBOL_WIDTH bits): the full codeword packed as RS_Decoder's codeword input. The first-transmitted symbol occupies bits [N*SW-1 -: SW]; the last parity symbol occupies bits [SW-1:0].
- cw_data is assembled in a shift register as symbols are loaded into the output register.
- cw_valid pulses the cycle after the PAR2 load. cw_data holds until the next pulse.
- Reset clears both outputs to 0.
- When not defined, neither port exists and there is no shift-register logic.

Test Plan:
- Reset, K=5, message 000,000,000,000,000, out_ready=1 -> 7 symbols, all 000; sop on symbol 0, eop on symbol 6; frame completes within 7 cycles of the first accept.
- Message 000,000,000,000,100 -> parity 011, then 110.
- Message 100,000,000,000,000 -> parity 011, then 010.
- Two frames back-to-back (second frame as the previous case) with in_valid held high -> 14 contiguous out_valid cycles, no bubble; second frame parity 011, 010.
- Random out_ready stalls and in_valid gaps on a random message -> output sequence identical to the unstalled run; outputs stable while stalled; in_ready=0 in PAR1/PAR2; every codeword satisfies c(a)=c(a^2)=0.
- Assert reset after 3 accepted symbols, then send the single-symbol-1 frame (000,000,000,000,100) -> outputs cleared immediately; new frame parity 011, 110.
- With RS_ENC_PARALLEL_OUT_EN defined, same frame -> cw_data=000_000_000_000_100_011_110, cw_valid high exactly one cycle.
